// File: rtl/tick_timer_ctrl.sv
// Bus-mapped compare/interrupt controller for the free-running tick count.
// Define TICK_TIMER_PERIODIC_EN to build the periodic auto-reload and OVR logic.
module tick_timer_ctrl #(
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF,
    parameter logic [31:0] PER_RESET = 32'd0
) (
    input  logic        clk_bus,
    input  logic        rst_n,
    input  logic [31:0] tick_value,
    input  logic [7:0]  bus_address,
    input  logic [31:0] bus_data_i,
    output logic [31:0] bus_data_o,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [5:0] A_CTRL    = 6'h00;
    localparam logic [5:0] A_STATUS  = 6'h01;
    localparam logic [5:0] A_COMPARE = 6'h02;
    localparam logic [5:0] A_PERIOD  = 6'h03;
    localparam logic [5:0] A_COUNT   = 6'h04;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        per_q, per_d;
    logic        pend_q, pend_d;
    logic        ovr_q, ovr_d;
    logic [31:0] cmp_q, cmp_d;
    logic [31:0] period_q, period_d;

    logic [5:0]  word_addr;
    logic        wr_ctrl, wr_status, wr_cmp, wr_period;
    logic [31:0] delta;
    logic        due, hit_raw, cancel, hit;
    logic        per_wr_val, reload, ovr_set;
    logic        unused_addr_bits;

    assign word_addr        = bus_address[7:2];
    assign unused_addr_bits = ^bus_address[1:0];

    assign wr_ctrl   = bus_write && (word_addr == A_CTRL);
    assign wr_status = bus_write && (word_addr == A_STATUS);
    assign wr_cmp    = bus_write && (word_addr == A_COMPARE);
    assign wr_period = bus_write && (word_addr == A_PERIOD);

`ifdef TICK_TIMER_PERIODIC_EN
    assign per_wr_val = bus_data_i[2];
    assign reload     = per_q && (period_q != 32'd0);
`else
    assign per_wr_val = 1'b0;
    assign reload     = 1'b0;
`endif

    // Wrap-safe "tick has reached compare": sign of the modular difference.
    assign delta   = tick_value - cmp_q;
    assign due     = ~delta[31];
    assign hit_raw = en_q && (state_q == ST_ARMED) && due;
    assign cancel  = (wr_ctrl && !bus_data_i[0]) || (wr_cmp && en_q);
    assign hit     = hit_raw && !cancel;
    assign ovr_set = hit && reload && pend_q;

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        ie_d     = ie_q;
        per_d    = per_q;
        cmp_d    = cmp_q;
        period_d = period_q;
        pend_d   = (pend_q & ~(wr_status & bus_data_i[0])) | hit;
        ovr_d    = (ovr_q  & ~(wr_status & bus_data_i[1])) | ovr_set;

        if (hit) begin
            if (reload) begin
                cmp_d = cmp_q + period_q;
            end else begin
                state_d = ST_DONE;
            end
        end

        if (wr_ctrl) begin
            en_d  = bus_data_i[0];
            ie_d  = bus_data_i[1];
            per_d = per_wr_val;
            if (!bus_data_i[0]) begin
                state_d = ST_IDLE;
            end else if (state_q == ST_IDLE) begin
                state_d = ST_ARMED;
            end
        end

        // A new compare point re-arms and hides any hit against the old one.
        if (wr_cmp) begin
            cmp_d = bus_data_i;
            if (en_q) begin
                state_d = ST_ARMED;
            end
        end

        if (wr_period) begin
            period_d = bus_data_i;
        end
    end

    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            per_q    <= 1'b0;
            pend_q   <= 1'b0;
            ovr_q    <= 1'b0;
            cmp_q    <= CMP_RESET;
            period_q <= PER_RESET;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            ie_q     <= ie_d;
            per_q    <= per_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            cmp_q    <= cmp_d;
            period_q <= period_d;
        end
    end

    always_comb begin
        bus_data_o = 32'd0;
        if (bus_read) begin
            case (word_addr)
                A_CTRL:    bus_data_o = {29'd0, per_q, ie_q, en_q};
                A_STATUS:  bus_data_o = {30'd0, ovr_q, pend_q};
                A_COMPARE: bus_data_o = cmp_q;
                A_PERIOD:  bus_data_o = period_q;
                A_COUNT:   bus_data_o = tick_value;
                default:   bus_data_o = 32'd0;
            endcase
        end
    end

    assign irq_o = pend_q & ie_q;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Self-checking bench for tick_timer_ctrl: a behavioural register/scheduling model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tick_timer_ctrl;

`ifdef TICK_TIMER_PERIODIC_EN
    localparam bit PERIODIC_BUILD = 1'b1;
`else
    localparam bit PERIODIC_BUILD = 1'b0;
`endif

    logic        clk_bus = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tick_value = 32'd0;
    logic [7:0]  bus_address = 8'd0;
    logic [31:0] bus_data_i = 32'd0;
    logic [31:0] bus_data_o;
    logic        bus_read = 1'b0;
    logic        bus_write = 1'b0;
    logic        irq_o;

    int checks = 0;
    int failures = 0;

    tick_timer_ctrl dut (
        .clk_bus     (clk_bus),
        .rst_n       (rst_n),
        .tick_value  (tick_value),
        .bus_address (bus_address),
        .bus_data_i  (bus_data_i),
        .bus_data_o  (bus_data_o),
        .bus_read    (bus_read),
        .bus_write   (bus_write),
        .irq_o       (irq_o)
    );

    always #5 clk_bus = ~clk_bus;

    // Behavioural model: "waiting" means a one-shot/periodic deadline is outstanding.
    bit          m_valid = 1'b0;
    bit          m_en, m_ie, m_per, m_pend, m_ovr, m_waiting, m_fire;
    logic [31:0] m_cmp, m_period;
    int          m_dist;
    int          m_reg;

    always @(posedge clk_bus) begin
        if (!rst_n) begin
            m_valid   = 1'b1;
            m_en      = 1'b0;
            m_ie      = 1'b0;
            m_per     = 1'b0;
            m_pend    = 1'b0;
            m_ovr     = 1'b0;
            m_waiting = 1'b0;
            m_cmp     = 32'hFFFF_FFFF;
            m_period  = 32'd0;
        end else begin
            m_reg  = int'(bus_address) / 4;
            m_dist = int'(tick_value - m_cmp);
            m_fire = m_en && m_waiting && (m_dist >= 0);
            if (bus_write && m_reg == 0 && bus_data_i[0] == 1'b0) m_fire = 1'b0;
            if (bus_write && m_reg == 2 && m_en) m_fire = 1'b0;
            if (bus_write && m_reg == 1) begin
                if (bus_data_i[0]) m_pend = 1'b0;
                if (bus_data_i[1]) m_ovr = 1'b0;
            end
            if (m_fire) begin
                if (m_per && m_period != 0) begin
                    if (m_pend) m_ovr = 1'b1;
                    m_cmp = m_cmp + m_period;
                end else begin
                    m_waiting = 1'b0;
                end
                m_pend = 1'b1;
            end
            if (bus_write) begin
                case (m_reg)
                    0: begin
                        if (!bus_data_i[0]) m_waiting = 1'b0;
                        else if (!m_en) m_waiting = 1'b1;
                        m_en  = bus_data_i[0];
                        m_ie  = bus_data_i[1];
                        m_per = PERIODIC_BUILD && bus_data_i[2];
                    end
                    2: begin
                        m_cmp = bus_data_i;
                        if (m_en) m_waiting = 1'b1;
                    end
                    3: m_period = bus_data_i;
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] modelRead();
        if (!bus_read) return 32'd0;
        case (int'(bus_address) / 4)
            0: return {29'd0, m_per, m_ie, m_en};
            1: return {30'd0, m_ovr, m_pend};
            2: return m_cmp;
            3: return m_period;
            4: return tick_value;
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_bus) begin
        if (m_valid) begin
            checkOutput("model_irq", {31'd0, irq_o}, {31'd0, m_pend & m_ie});
            checkOutput("model_rdata", bus_data_o, modelRead());
        end
    end

    // One bus/tick cycle; inputs change 1 time unit after the active edge.
    task automatic applyStimulus(input bit wr, input bit rd, input logic [7:0] addr,
                                 input logic [31:0] data, input logic [31:0] tick);
        bus_write   = wr;
        bus_read    = rd;
        bus_address = addr;
        bus_data_i  = data;
        tick_value  = tick;
        @(posedge clk_bus);
        #1;
        bus_write = 1'b0;
        bus_read  = 1'b0;
    endtask

    task automatic busWrite(input logic [7:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, data, tick_value);
    endtask

    task automatic readCheck(input string name, input logic [7:0] addr, input logic [31:0] expected);
        bus_read    = 1'b1;
        bus_address = addr;
        #3;
        checkOutput(name, bus_data_o, expected);
        @(posedge clk_bus);
        #1;
        bus_read = 1'b0;
    endtask

    task automatic irqCheck(input string name, input bit expected);
        checkOutput(name, {31'd0, irq_o}, {31'd0, expected});
    endtask

    initial begin
        logic [31:0] t;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_bus);
        #1;
        rst_n = 1'b1;
        irqCheck("reset_irq", 1'b0);
        readCheck("reset_ctrl", 8'h00, 32'd0);
        readCheck("reset_status", 8'h04, 32'd0);
        readCheck("reset_compare", 8'h08, 32'hFFFF_FFFF);
        readCheck("reset_period", 8'h0C, 32'd0);

        $display("[TB] one-shot");
        busWrite(8'h08, 32'd100);
        busWrite(8'h00, 32'd3);
        for (int i = 95; i <= 105; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, i);
            irqCheck("oneshot_irq", i >= 100);
        end
        readCheck("oneshot_status", 8'h04, 32'd1);
        busWrite(8'h04, 32'd1);
        irqCheck("oneshot_w1c_irq", 1'b0);
        for (int i = 106; i <= 110; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, i);
        end
        irqCheck("oneshot_norefire", 1'b0);

        $display("[TB] wrap");
        busWrite(8'h00, 32'd0);
        busWrite(8'h04, 32'd3);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, 32'hFFFF_FFF0);
        busWrite(8'h08, 32'd5);
        busWrite(8'h00, 32'd3);
        for (int i = 0; i < 24; i++) begin
            t = 32'hFFFF_FFF0 + i;
            applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, t);
            irqCheck("wrap_irq", i >= 21);
        end

        $display("[TB] W1C collision");
        busWrite(8'h00, 32'd0);
        busWrite(8'h04, 32'd3);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, 32'd40);
        busWrite(8'h08, 32'd50);
        busWrite(8'h00, 32'd3);
        applyStimulus(1'b1, 1'b0, 8'h04, 32'd1, 32'd50);
        irqCheck("w1c_collision_irq", 1'b1);
        readCheck("w1c_collision_status", 8'h04, 32'd1);

        $display("[TB] COMPARE collision");
        busWrite(8'h00, 32'd0);
        busWrite(8'h04, 32'd3);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, 32'd55);
        busWrite(8'h08, 32'd60);
        busWrite(8'h00, 32'd3);
        applyStimulus(1'b1, 1'b0, 8'h08, 32'd70, 32'd60);
        irqCheck("cmp_collision_irq", 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, 32'd65);
        irqCheck("cmp_collision_65", 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, 32'd70);
        irqCheck("cmp_collision_70", 1'b1);

        $display("[TB] disable");
        busWrite(8'h00, 32'd0);
        busWrite(8'h04, 32'd3);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, 32'd75);
        busWrite(8'h08, 32'd80);
        busWrite(8'h00, 32'd3);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'd0, 32'd80);
        irqCheck("disable_irq", 1'b0);
        readCheck("disable_status", 8'h04, 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, 32'd85);
        irqCheck("idle_no_fire", 1'b0);
        busWrite(8'h00, 32'd3);
        irqCheck("past_arm_first", 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, 32'd85);
        irqCheck("past_arm_fire", 1'b1);

        $display("[TB] periodic");
        busWrite(8'h00, 32'd0);
        busWrite(8'h04, 32'd3);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, 32'd0);
        busWrite(8'h0C, 32'd10);
        busWrite(8'h08, 32'd10);
        busWrite(8'h00, 32'd7);
        readCheck("periodic_ctrl", 8'h00, PERIODIC_BUILD ? 32'd7 : 32'd3);
        for (int i = 5; i <= 35; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, i);
            irqCheck("periodic_irq", i >= 10);
        end
        readCheck("periodic_compare", 8'h08, PERIODIC_BUILD ? 32'd40 : 32'd10);
        readCheck("periodic_status", 8'h04, PERIODIC_BUILD ? 32'd3 : 32'd1);
        readCheck("periodic_period", 8'h0C, 32'd10);

        $display("[TB] decode");
        readCheck("addr_low_bits", 8'h0B, PERIODIC_BUILD ? 32'd40 : 32'd10);
        readCheck("unmapped_read", 8'h14, 32'd0);
        busWrite(8'h20, 32'hDEAD_BEEF);
        readCheck("unmapped_write", 8'h20, 32'd0);
        tick_value = 32'h1234_5678;
        readCheck("count_read", 8'h10, 32'h1234_5678);

        $display("[TB] reset mid-operation");
        irqCheck("pre_reset_irq", 1'b1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, 32'd50);
        rst_n = 1'b1;
        irqCheck("midreset_irq", 1'b0);
        readCheck("midreset_status", 8'h04, 32'd0);
        readCheck("midreset_compare", 8'h08, 32'hFFFF_FFFF);

        @(negedge clk_bus);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
